// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the MEM stage
// (core port) and the debug/loader port; stalls the core and counts debug conflicts.
module dmem_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_wr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic [CNT_W-1:0]  conflict_cnt
);

   typedef enum logic [1:0] {IDLE, CORE_RD, DBG_RD} state_t;
   typedef enum logic {GNT_CORE, GNT_DBG} grant_t;

   state_t state, state_nx;
   grant_t last_grant, last_grant_nx;
   logic   core_win, dbg_win, cnt_inc;

   // All outputs are forced low while reset is high, independent of state.
   always_comb begin
      state_nx      = state;
      last_grant_nx = last_grant;
      core_win      = 1'b0;
      dbg_win       = 1'b0;
      cnt_inc       = 1'b0;
      mem_wr        = 1'b0;
      mem_rd        = 1'b0;
      mem_addr      = '0;
      mem_wr_data   = '0;
      core_stall    = 1'b0;
      core_rdata    = '0;
      dbg_gnt       = 1'b0;
      dbg_rvalid    = 1'b0;
      dbg_rdata     = '0;
      if (!reset) begin
         case (state)
            IDLE: begin
               core_win = core_req & (~dbg_req | (last_grant == GNT_DBG));
               dbg_win  = dbg_req & ~core_win;
               if (core_win) begin
                  mem_wr        = core_we;
                  mem_rd        = ~core_we;
                  mem_addr      = core_addr;
                  mem_wr_data   = core_wdata;
                  last_grant_nx = GNT_CORE;
                  if (!core_we) state_nx = CORE_RD;
               end else if (dbg_win) begin
                  mem_wr        = dbg_we;
                  mem_rd        = ~dbg_we;
                  mem_addr      = dbg_addr;
                  mem_wr_data   = dbg_wdata;
                  dbg_gnt       = 1'b1;
                  last_grant_nx = GNT_DBG;
                  if (!dbg_we) state_nx = DBG_RD;
               end
               // A store granted this cycle completes immediately; everything else waits.
               core_stall = core_req & ~(core_win & core_we);
               cnt_inc    = core_req & dbg_win;
            end
            CORE_RD: begin
               core_rdata = mem_rd_data;
               state_nx   = IDLE;
            end
            DBG_RD: begin
               dbg_rvalid = 1'b1;
               dbg_rdata  = mem_rd_data;
               core_stall = core_req;
               cnt_inc    = core_req;
               state_nx   = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         last_grant   <= GNT_DBG;
         conflict_cnt <= '0;
      end else begin
         state      <= state_nx;
         last_grant <= last_grant_nx;
         if (cnt_inc && (conflict_cnt != '1))
            conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter, checked cycle by cycle against
// a transaction-level reference model with its own copy of memory.
module tb_dmem_arbiter;
   localparam int DW = 32;
   localparam int AW = 9;
   localparam int BW = 5 + AW + 3 * DW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          core_req, core_we, dbg_req, dbg_we;
   logic [AW-1:0] core_addr, dbg_addr;
   logic [DW-1:0] core_wdata, dbg_wdata;
   logic [DW-1:0] mem_rd_data;

   logic [DW-1:0] core_rdata, dbg_rdata, mem_wr_data;
   logic          core_stall, dbg_gnt, dbg_rvalid, mem_wr, mem_rd;
   logic [AW-1:0] mem_addr;
   logic [15:0]   conflict_cnt;

   logic [DW-1:0] core_rdata2, dbg_rdata2, mem_wr_data2;
   logic          core_stall2, dbg_gnt2, dbg_rvalid2, mem_wr2, mem_rd2;
   logic [AW-1:0] mem_addr2;
   logic [1:0]    conflict_cnt2;

   dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_rdata(core_rdata), .core_stall(core_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_data(mem_rd_data), .conflict_cnt(conflict_cnt));

   // Narrow-counter copy so saturation is reachable in a few cycles.
   dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_rdata(core_rdata2), .core_stall(core_stall2),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt2), .dbg_rvalid(dbg_rvalid2), .dbg_rdata(dbg_rdata2),
      .mem_wr(mem_wr2), .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_wr_data(mem_wr_data2),
      .mem_rd_data(mem_rd_data), .conflict_cnt(conflict_cnt2));

   // Environment memory driven by the main DUT.
   logic [DW-1:0] env_mem [512];
   always @(posedge clk) begin
      if (mem_wr) env_mem[mem_addr] <= mem_wr_data;
      if (mem_rd) mem_rd_data <= env_mem[mem_addr];
   end

   // Reference model state.
   int            m_busy;       // 0 none, 1 core read returning, 2 debug read returning
   bit            m_last_core;  // last issue went to the core
   int            m_cnt, m_cnt2;
   logic [AW-1:0] m_raddr;
   logic [DW-1:0] m_mem [512];
   bit            last_stall, last_gnt;

   int vectors = 0;
   int miscompares = 0;

   task automatic cycle();
      logic          e_wr, e_rd, e_stall, e_gnt, e_rv;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata, e_crdata, e_drdata;
      logic [BW-1:0] exp_b, obs_b, obs_b2;
      bit            cw, dw;
      @(negedge clk);
      e_wr = 0; e_rd = 0; e_stall = 0; e_gnt = 0; e_rv = 0;
      e_addr = '0; e_wdata = '0; e_crdata = '0; e_drdata = '0;
      cw = 0; dw = 0;
      if (!reset) begin
         if (m_busy == 1) begin
            e_crdata = m_mem[m_raddr];
         end else if (m_busy == 2) begin
            e_rv = 1; e_drdata = m_mem[m_raddr]; e_stall = core_req;
         end else begin
            if (core_req && (!dbg_req || !m_last_core)) cw = 1;
            else if (dbg_req) dw = 1;
            if (cw) begin
               e_wr = core_we; e_rd = !core_we; e_addr = core_addr; e_wdata = core_wdata;
               e_stall = !core_we;
            end else if (dw) begin
               e_gnt = 1; e_wr = dbg_we; e_rd = !dbg_we; e_addr = dbg_addr; e_wdata = dbg_wdata;
               e_stall = core_req;
            end
         end
      end
      exp_b  = {e_wr, e_rd, e_stall, e_gnt, e_rv, e_addr, e_wdata, e_crdata, e_drdata};
      obs_b  = {mem_wr, mem_rd, core_stall, dbg_gnt, dbg_rvalid, mem_addr, mem_wr_data, core_rdata, dbg_rdata};
      obs_b2 = {mem_wr2, mem_rd2, core_stall2, dbg_gnt2, dbg_rvalid2, mem_addr2, mem_wr_data2, core_rdata2, dbg_rdata2};
      vectors++;
      assert (obs_b === exp_b) else begin
         miscompares++;
         $error("FAIL outputs observed=%h expected=%h", obs_b, exp_b);
      end
      assert (obs_b2 === exp_b) else begin
         miscompares++;
         $error("FAIL outputs_sat observed=%h expected=%h", obs_b2, exp_b);
      end
      assert (conflict_cnt === 16'(m_cnt)) else begin
         miscompares++;
         $error("FAIL conflict_cnt observed=%h expected=%h", conflict_cnt, 16'(m_cnt));
      end
      assert (conflict_cnt2 === 2'(m_cnt2)) else begin
         miscompares++;
         $error("FAIL conflict_cnt_sat observed=%h expected=%h", conflict_cnt2, 2'(m_cnt2));
      end
      last_stall = e_stall;
      last_gnt   = e_gnt;
      @(posedge clk);
      if (reset) begin
         m_busy = 0; m_last_core = 0; m_cnt = 0; m_cnt2 = 0;
      end else begin
         if (core_req && (dw || m_busy == 2)) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
         end
         m_busy = 0;
         if (cw) begin
            m_last_core = 1;
            if (core_we) m_mem[core_addr] = core_wdata;
            else begin m_busy = 1; m_raddr = core_addr; end
         end else if (dw) begin
            m_last_core = 0;
            if (dbg_we) m_mem[dbg_addr] = dbg_wdata;
            else begin m_busy = 2; m_raddr = dbg_addr; end
         end
      end
      #1;
   endtask

   task automatic spot(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         env_mem[i] = 32'hC0DE0000 ^ (i * 32'h01010101);
         m_mem[i]   = 32'hC0DE0000 ^ (i * 32'h01010101);
      end
      env_mem[511] = 32'h12345678;
      m_mem[511]   = 32'h12345678;
      mem_rd_data = '0;
      m_busy = 0; m_last_core = 0; m_cnt = 0; m_cnt2 = 0; m_raddr = '0;
      last_stall = 0; last_gnt = 0;
      reset = 1;
      core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
      cycle();
      core_req = 1; dbg_req = 1; dbg_we = 0;
      cycle();
      reset = 0; core_req = 0; dbg_req = 0;
      cycle();

      // Core store then load of the same word.
      core_req = 1; core_we = 1; core_addr = 9'h005; core_wdata = 32'hDEADBEEF;
      cycle();
      core_we = 0;
      cycle();
      cycle();
      core_req = 0;
      reset = 1;
      cycle();
      reset = 0;

      // Simultaneous requests: core wins first, debug wins the next conflict.
      core_req = 1; core_we = 0; core_addr = 9'h010;
      dbg_req = 1; dbg_we = 1; dbg_addr = 9'h020; dbg_wdata = 32'hA5A5A5A5;
      cycle();
      cycle();
      spot("cnt_after_core_first", conflict_cnt, 16'd0);
      core_addr = 9'h011;
      cycle();
      spot("cnt_after_dbg_win", conflict_cnt, 16'd1);
      dbg_req = 0;
      cycle();
      cycle();
      core_req = 0;

      // Debug read of the top word, core store arriving during DBG_RD.
      dbg_req = 1; dbg_we = 0; dbg_addr = 9'h1FF;
      cycle();
      dbg_req = 0;
      core_req = 1; core_we = 1; core_addr = 9'h003; core_wdata = 32'h00000007;
      cycle();
      spot("cnt_after_dbg_rd", conflict_cnt, 16'd2);
      cycle();
      core_req = 0;

      // Reset in the cycle after a debug read issue.
      dbg_req = 1; dbg_we = 0; dbg_addr = 9'h1FF;
      cycle();
      dbg_req = 0; reset = 1;
      cycle();
      reset = 0;
      cycle();
      spot("cnt_after_reset", conflict_cnt, 16'd0);

      // Sustained conflicts: narrow counter must saturate and hold.
      core_req = 1; core_we = 0; core_addr = 9'h001;
      dbg_req = 1; dbg_we = 0; dbg_addr = 9'h002;
      for (int i = 0; i < 14; i++) cycle();
      spot("cnt_sat", 16'(conflict_cnt2), 16'd3);
      core_req = 0; dbg_req = 0;
      cycle();

      // Randomized traffic honouring both handshakes.
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 79) == 0);
         if (!(core_req && last_stall)) begin
            core_req   = ($urandom_range(0, 3) != 0);
            core_we    = $urandom_range(0, 1) == 1;
            core_addr  = AW'($urandom_range(0, 31));
            core_wdata = $urandom;
         end
         if (!(dbg_req && !last_gnt)) begin
            dbg_req   = ($urandom_range(0, 2) == 0);
            dbg_we    = $urandom_range(0, 1) == 1;
            dbg_addr  = AW'($urandom_range(0, 31));
            dbg_wdata = $urandom;
         end
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
